// File: rtl/reconf_fir_seq_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// self-sequenced reconfigurable FIR filter.
package fir_pkg;

  localparam int unsigned TAPS_DEF     = 10;
  localparam int unsigned NUM_BANK_DEF = 2;
  localparam int unsigned IN_W_DEF     = 3;
  localparam int unsigned COEF_W_DEF   = 16;
  localparam int unsigned OUT_W_DEF    = 16;
  localparam int unsigned SHIFT_DEF    = 0;
  localparam int unsigned TAP_W_DEF    = $clog2(TAPS_DEF);
  localparam int unsigned BANK_W_DEF   = (NUM_BANK_DEF > 1) ? $clog2(NUM_BANK_DEF) : 1;

  // Wide enough for any sign-extended accumulator this block is built with.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } fir_state_e;

  // Clip a sign-extended accumulator value to the signed range of out_w bits.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             out_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/reconf_fir_seq_if.sv
// Sample, coefficient-write and result signals of the FIR filter.
interface reconf_fir_seq_if
  import fir_pkg::*;
#(
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned TAP_W  = TAP_W_DEF,
  parameter int unsigned BANK_W = BANK_W_DEF
);
  logic              iEnSample600k;
  logic [IN_W-1:0]   iFirIn;
  logic [BANK_W-1:0] iBankSel;
  logic              iCoeffUpdateFlag;
  logic              iCoeffWe;
  logic [BANK_W-1:0] iCoeffBank;
  logic [TAP_W-1:0]  iCoeffAddr;
  logic [COEF_W-1:0] iCoeffData;
  logic [OUT_W-1:0]  oFirOut;
  logic              oFirValid;
  logic              oBusy;
  logic              oOverrun;
  logic              oWrConflict;

  modport master (
    output iEnSample600k, iFirIn, iBankSel, iCoeffUpdateFlag,
           iCoeffWe, iCoeffBank, iCoeffAddr, iCoeffData,
    input  oFirOut, oFirValid, oBusy, oOverrun, oWrConflict
  );

  modport slave (
    input  iEnSample600k, iFirIn, iBankSel, iCoeffUpdateFlag,
           iCoeffWe, iCoeffBank, iCoeffAddr, iCoeffData,
    output oFirOut, oFirValid, oBusy, oOverrun, oWrConflict
  );
endinterface

// File: rtl/reconf_fir_seq_coeff_ram.sv
// Coefficient store: NUM_BANK*TAPS words, one write port and one
// synchronous read port, both addressed as {bank, tap}.
module fir_coeff_ram #(
  parameter int unsigned TAPS     = 10,
  parameter int unsigned NUM_BANK = 2,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned TAP_W    = 4,
  parameter int unsigned BANK_W   = 1
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [BANK_W+TAP_W-1:0]   wr_addr,
  input  logic [COEF_W-1:0]         wr_data,
  input  logic [BANK_W+TAP_W-1:0]   rd_addr,
  output logic [COEF_W-1:0]         rd_data
);
  localparam int unsigned DEPTH = NUM_BANK * TAPS;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [COEF_W-1:0] mem [DEPTH];
  logic [COEF_W-1:0] rd_data_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Pack {bank, tap} densely so non-power-of-two TAPS wastes no words.
  always_comb begin
    wr_idx = IDX_W'(32'(wr_addr[BANK_W+TAP_W-1:TAP_W]) * TAPS + 32'(wr_addr[TAP_W-1:0]));
    rd_idx = IDX_W'(32'(rd_addr[BANK_W+TAP_W-1:TAP_W]) * TAPS + 32'(rd_addr[TAP_W-1:0]));
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
    rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/reconf_fir_seq.sv
// Self-sequenced FIR: delay line, banked coefficients and one time-shared
// MAC walked through all taps by a small FSM on every accepted sample strobe.
module reconf_fir_seq
  import fir_pkg::*;
#(
  parameter int unsigned TAPS     = TAPS_DEF,
  parameter int unsigned NUM_BANK = NUM_BANK_DEF,
  parameter int unsigned IN_W     = IN_W_DEF,
  parameter int unsigned COEF_W   = COEF_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned SHIFT    = SHIFT_DEF
) (
  input logic             iClk12M,
  input logic             iRst,
  reconf_fir_seq_if.slave bus
);
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam int unsigned BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int unsigned ACC_W  = IN_W + COEF_W + $clog2(TAPS);

  fir_state_e              state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [BANK_W-1:0]       bank_q, bank_d;
  logic signed [IN_W-1:0]  dly_q [TAPS];
  logic signed [IN_W-1:0]  dly_d [TAPS];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]        out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    conflict_q, conflict_d;

  logic signed [ACC_W-1:0] x_ext, c_ext;
  logic [TAP_W-1:0]        rd_tap;
  logic [COEF_W-1:0]       rd_data;
  logic                    wr_ok, wr_hit, wr_en;

  fir_coeff_ram #(
    .TAPS(TAPS), .NUM_BANK(NUM_BANK), .COEF_W(COEF_W), .TAP_W(TAP_W), .BANK_W(BANK_W)
  ) u_ram (
    .clk    (iClk12M),
    .we     (wr_en),
    .wr_addr({bus.iCoeffBank, bus.iCoeffAddr}),
    .wr_data(bus.iCoeffData),
    .rd_addr({bank_q, rd_tap}),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    bank_d     = bank_q;
    dly_d      = dly_q;
    acc_d      = acc_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    overrun_d  = overrun_q;
    rd_tap     = '0;
    x_ext      = ACC_W'(dly_q[tap_q]);
    c_ext      = ACC_W'($signed(rd_data));

    case (state_q)
      IDLE: begin
        if (bus.iEnSample600k) begin
          for (int k = TAPS - 1; k > 0; k--) dly_d[k] = dly_q[k-1];
          dly_d[0] = $signed(bus.iFirIn);
          if (!bus.iCoeffUpdateFlag) begin
            bank_d  = bus.iBankSel;
            acc_d   = '0;
            tap_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: state_d = MAC;
      // Coefficient for tap_q arrived this cycle; prefetch the next one.
      MAC: begin
        acc_d = acc_q + x_ext * c_ext;
        if (tap_q == TAP_W'(TAPS - 1)) begin
          state_d = DONE;
        end else begin
          tap_d  = tap_q + TAP_W'(1);
          rd_tap = tap_q + TAP_W'(1);
        end
      end
      DONE: begin
        out_d   = OUT_W'(saturate(SAT_W'(acc_q >>> SHIFT), OUT_W));
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.iEnSample600k && state_q != IDLE) overrun_d = 1'b1;

    // Out-of-range writes vanish; writes racing the active MAC bank are refused.
    wr_ok      = bus.iCoeffUpdateFlag && bus.iCoeffWe &&
                 (32'(bus.iCoeffAddr) < TAPS) && (32'(bus.iCoeffBank) < NUM_BANK);
    wr_hit     = wr_ok && (state_q == FETCH || state_q == MAC) && (bus.iCoeffBank == bank_q);
    wr_en      = wr_ok && !wr_hit;
    conflict_d = wr_hit;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      bank_q     <= '0;
      dly_q      <= '{default: '0};
      acc_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      bank_q     <= bank_d;
      dly_q      <= dly_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.oFirOut     = out_q;
  assign bus.oFirValid   = valid_q;
  assign bus.oBusy       = busy_q;
  assign bus.oOverrun    = overrun_q;
  assign bus.oWrConflict = conflict_q;
endmodule
